// File: rtl/led_pkg.sv
// Shared mode encoding for the LED mode controller and its press-driven
// mode sequencing helper.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_e;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_OFF:     return MODE_ON;
      MODE_ON:      return MODE_BLINK;
      MODE_BLINK:   return MODE_BREATHE;
      default:      return MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button front end: 2-flop synchronizer, stability debounce and a
// single-cycle press pulse on the debounced 1->0 transition.
module key_debounce #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          db_q, press_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      db_q    <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q != db_q) begin
        if (cnt_q == CNT_LAST) begin
          db_q    <= sync2_q;
          cnt_q   <= '0;
          // Old level 1 means the accepted level is 0: a press, never a release.
          press_q <= db_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// Single-button LED controller cycling OFF -> ON -> BLINK -> BREATHE with a
// registered LED output driven from the current mode's waveform state.
module led_mode_ctrl
  import led_pkg::*;
#(
  parameter int DB_CYCLES   = 1_000_000,
  parameter int BLINK_DIV   = 12_500_000,
  parameter int BREATHE_DIV = 48_828,
  parameter int PWM_BITS    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  output logic       led,
  output logic [1:0] mode
);

  localparam int BW = (BLINK_DIV > 1)   ? $clog2(BLINK_DIV)   : 1;
  localparam int SW = (BREATHE_DIV > 1) ? $clog2(BREATHE_DIV) : 1;
  localparam logic [BW-1:0]       BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [SW-1:0]       STEP_LAST  = SW'(BREATHE_DIV - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX   = '1;

  logic press;

  mode_e               state_q, state_d;
  logic                led_q, led_d;
  logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                blink_q, blink_d;
  logic [SW-1:0]       step_cnt_q, step_cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic                up_q, up_d;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_n),
    .press (press)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MODE_OFF;
      led_q       <= 1'b0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      step_cnt_q  <= '0;
      duty_q      <= '0;
      pwm_q       <= '0;
      up_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      led_q       <= led_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      step_cnt_q  <= step_cnt_d;
      duty_q      <= duty_d;
      pwm_q       <= pwm_d;
      up_q        <= up_d;
    end
  end

  always_comb begin
    state_d     = press ? next_mode(state_q) : state_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    step_cnt_d  = step_cnt_q;
    duty_d      = duty_q;
    pwm_d       = pwm_q;
    up_d        = up_q;
    led_d       = 1'b0;

    case (state_q)
      MODE_BLINK: begin
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_d = '0;
          blink_d     = ~blink_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end
      MODE_BREATHE: begin
        pwm_d = pwm_q + 1'b1;
        if (step_cnt_q == STEP_LAST) begin
          step_cnt_d = '0;
          // At either end flip direction without moving, so the end duty lasts one step.
          if (up_q) begin
            if (duty_q == DUTY_MAX) up_d = 1'b0;
            else                    duty_d = duty_q + 1'b1;
          end else begin
            if (duty_q == '0) up_d = 1'b1;
            else              duty_d = duty_q - 1'b1;
          end
        end else begin
          step_cnt_d = step_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    // A press restarts every waveform, overriding any terminal-count update above.
    if (press) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
      step_cnt_d  = '0;
      duty_d      = '0;
      pwm_d       = '0;
      up_d        = 1'b1;
    end

    case (state_q)
      MODE_OFF:     led_d = 1'b0;
      MODE_ON:      led_d = 1'b1;
      MODE_BLINK:   led_d = blink_q;
      default:      led_d = (pwm_q < duty_q);
    endcase
  end

  assign led  = led_q;
  assign mode = state_q;

endmodule

// File: doc/led_mode_ctrl.md
LED_MODE_CTRL -- requirements
Module: led_mode_ctrl

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 1_000_000: consecutive stable cycles needed to accept a key level (20 ms at 50 MHz).
REQ-002 SHALL have parameter BLINK_DIV, default 12_500_000: cycles per blink half-period.
REQ-003 SHALL have parameter BREATHE_DIV, default 48_828: cycles per breathe duty step.
REQ-004 SHALL have parameter PWM_BITS, default 8: width of the PWM counter and the duty register.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port key_n, input, 1 bit: raw push-button, active-low, asynchronous, bouncing.
REQ-008 SHALL have port led, output, 1 bit: registered LED drive, 1 = lit.
REQ-009 SHALL have port mode, output, 2 bits: current mode, where OFF=00, ON=01, BLINK=10, BREATHE=11.

Function
REQ-010 SHALL pass key_n through a 2-flop synchronizer; both flops reset to 1.
REQ-011 SHALL keep a debounced level that takes the synchronized value only after DB_CYCLES consecutive cycles in which that value differs from the debounced level; any return to the debounced level clears the stability counter to 0.
REQ-012 SHALL raise a one-cycle press pulse in the cycle the debounced level goes 1->0; a release (0->1) SHALL NOT raise a pulse.
REQ-013 SHALL advance mode on each press pulse: OFF->ON->BLINK->BREATHE->OFF, with wrap-around; mode SHALL otherwise hold.
REQ-014 SHALL drive led low in OFF and high in ON.
REQ-015 In BLINK, SHALL run a counter 0..BLINK_DIV-1 and toggle a blink bit when the counter is at BLINK_DIV-1, returning the counter to 0; led = blink bit; the first toggle to 1 SHALL occur BLINK_DIV cycles after BLINK is entered.
REQ-016 In BREATHE, SHALL run a step counter 0..BREATHE_DIV-1; each terminal count SHALL move duty by 1 in a triangle 0->2^PWM_BITS-1->0, reversing direction at each end so the end value is held for exactly one step.
REQ-017 In BREATHE, SHALL run a free-running PWM_BITS-bit PWM counter; led = 1 while pwm_cnt < duty, so duty=0 gives led constantly 0.
REQ-018 SHALL register led so it follows the internal mode/blink/PWM state with 1 cycle of latency.
REQ-019 On every mode change, SHALL clear the blink counter, blink bit, step counter, duty, PWM counter and direction (up) in the same cycle.
REQ-020 When a press pulse coincides with a blink or breathe terminal count, the mode change and clear SHALL win; the toggle/step is discarded.
REQ-021 SHALL treat a key held across reset release as a new press once it has been stable for DB_CYCLES (mode OFF->ON).
REQ-022 SHALL have mode equal to the FSM state register, with no added latency.

Reset
REQ-023 While rst=1 at a clk edge, SHALL set: mode=OFF, led=0, sync flops=1, debounced level=1, stability counter=0, and all blink/breathe counters, duty, blink bit=0, direction=up.
REQ-024 Reset asserted mid-operation (any mode, mid-debounce) SHALL take effect at the next clk edge; there is no partial state retention.

Structure
REQ-025 SHALL place the mode typedef (2-bit enum OFF/ON/BLINK/BREATHE) and its encodings in shared package led_pkg.
REQ-026 SHALL implement the synchronizer, debounce and press pulse (REQ-010..012) in sub-module key_debounce (ports clk, rst, key_n, press), parameterized by DB_CYCLES.
REQ-027 SHALL size all counters with $clog2 of their parameter; there SHALL be no magic widths.

Verification (sim parameters DB_CYCLES=4, BLINK_DIV=3, BREATHE_DIV=2, PWM_BITS=3)
REQ-028 Reset, key_n=1 for 20 cycles -> mode=00 and led=0 throughout.
REQ-029 key_n low with a bounce (low 2, high 1, low 6 cycles) -> exactly one press and mode=01; led=1 one cycle after the mode change.
REQ-030 Four clean presses -> mode sequence 01,10,11,00 (wrap); no pulse generated on any release.
REQ-031 In BLINK -> led toggles every 3 cycles, first rising edge 3+1 cycles after mode=10; a press in the toggle cycle -> mode=11, no toggle.
REQ-032 In BREATHE -> duty steps 0,1..7,7,6..0 every 2 cycles; led high for exactly duty of every 8 PWM cycles.
REQ-033 rst pulsed for 1 cycle while in BREATHE with key held low -> mode=00 and led=0 next cycle; mode=01 after 4 further stable cycles plus synchronizer delay.
